panel_serial_loader: RTL

- Front-panel deposit/examine engine for the bit-serial PDP-8 system.
- Sits upstream of the 1-bit-wide memory (word address ma, bit address ba, data mb, write strobe, read data membus) and takes the bus while the CPU is halted.
- Deposit: a parallel 12-bit word is written bit by bit. Examine: a word is read bit by bit into a parallel register.
- An external mux selects this block's ma/ba/mb/write whenever bus_own=1.

---
 rtl/pdp8_serial_pkg.sv | 22 ++
 rtl/panel_serial_loader_if.sv | 29 ++
 rtl/serial_bit_counter.sv | 36 +++
 rtl/panel_serial_loader.sv | 98 +++++++++
 4 files changed

// File: rtl/pdp8_serial_pkg.sv
// Shared constants and state encoding for the bit-serial PDP-8 memory path.
// Used by the front-panel loader and the CPU bit sequencer.
package pdp8_serial_pkg;
   localparam int AW  = 7;
   localparam int WW  = 12;
   localparam int BAW = 4;

   localparam logic [BAW-1:0] BIT_LAST = 4'd11;

   localparam logic OP_EXAMINE = 1'b0;
   localparam logic OP_DEPOSIT = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      STROBE,
      HOLD,
      RSET,
      RSAMP,
      DONE
   } state_t;
endpackage

// File: rtl/panel_serial_loader_if.sv
// Request/response and serial memory bus bundle for the panel loader.
// master = panel/memory side, slave = the loader itself.
interface panel_serial_loader_if;
   import pdp8_serial_pkg::*;

   logic          req;
   logic          op;
   logic [AW-1:0] addr;
   logic [WW-1:0] wdata;
   logic          busy;
   logic          done;
   logic [WW-1:0] rdata;
   logic          bus_own;
   logic [AW-1:0] ma;
   logic [BAW-1:0] ba;
   logic          mb;
   logic          write;
   logic          membus;

   modport master (
      output req, op, addr, wdata, membus,
      input  busy, done, rdata, bus_own, ma, ba, mb, write
   );

   modport slave (
      input  req, op, addr, wdata, membus,
      output busy, done, rdata, bus_own, ma, ba, mb, write
   );
endinterface

// File: rtl/serial_bit_counter.sv
// Bit-address counter: clear, increment, saturates at LAST.
// Shared between the panel loader and the CPU bit sequencer.
module serial_bit_counter #(
   parameter int           W    = 4,
   parameter logic [W-1:0] LAST = {W{1'b1}}
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt,
   output logic         is_last
);
   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   assign is_last = (cnt_q == LAST);
   assign cnt     = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && !is_last) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/panel_serial_loader.sv
// Front-panel deposit/examine engine driving the 1-bit-wide core memory
// while the CPU is halted.
module panel_serial_loader
   import pdp8_serial_pkg::*;
(
   input  logic sysclk,
   input  logic reset,
   input  logic cpu_halted,
   panel_serial_loader_if.slave bus
);
   state_t         state_q;
   state_t         state_d;
   logic [AW-1:0]  ma_q;
   logic [AW-1:0]  ma_d;
   logic [WW-1:0]  wdata_q;
   logic [WW-1:0]  wdata_d;
   logic [WW-1:0]  rdata_q;
   logic [WW-1:0]  rdata_d;
   logic           cnt_clr;
   logic           cnt_inc;
   logic [BAW-1:0] ba;
   logic           is_last;
   logic           dep_phase;
   logic           busy;

   serial_bit_counter #(
      .W    (BAW),
      .LAST (BIT_LAST)
   ) u_bit_cnt (
      .clk     (sysclk),
      .rst     (reset),
      .clr     (cnt_clr),
      .inc     (cnt_inc),
      .cnt     (ba),
      .is_last (is_last)
   );

   always_comb begin
      state_d = state_q;
      ma_d    = ma_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      cnt_clr = 1'b0;
      cnt_inc = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.req && cpu_halted) begin
               ma_d    = bus.addr;
               wdata_d = bus.wdata;
               cnt_clr = 1'b1;
               state_d = (bus.op == OP_DEPOSIT) ? SETUP : RSET;
            end
         end
         SETUP:  state_d = STROBE;
         STROBE: state_d = HOLD;
         HOLD: begin
            cnt_inc = !is_last;
            state_d = is_last ? DONE : SETUP;
         end
         RSET:   state_d = RSAMP;
         RSAMP: begin
            rdata_d[ba] = bus.membus;
            cnt_inc     = !is_last;
            state_d     = is_last ? DONE : RSET;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         ma_q    <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         ma_q    <= ma_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   // mb is held from SETUP through HOLD so the falling-edge commit is clean
   assign dep_phase = (state_q == SETUP) || (state_q == STROBE)
                   || (state_q == HOLD);
   assign busy      = (state_q != IDLE) && (state_q != DONE);

   assign bus.busy    = busy;
   assign bus.bus_own = busy;
   assign bus.done    = (state_q == DONE);
   assign bus.write   = (state_q == STROBE);
   assign bus.mb      = dep_phase ? wdata_q[ba] : 1'b0;
   assign bus.ma      = ma_q;
   assign bus.ba      = ba;
   assign bus.rdata   = rdata_q;
endmodule
